// File: rtl/mfp_ahb_lite_param_interconnect_if.sv
// AHB-Lite bus bundle between one master, the interconnect and N slave ports.
// The interconnect uses the slave modport; the surrounding master/slave environment uses master.
interface mfp_ahb_lite_param_interconnect_if #(
    parameter int N_SLAVES = 4
) ();
    logic [31:0]            HADDR;
    logic [1:0]             HTRANS;
    logic                   HREADY;
    logic [31:0]            HRDATA;
    logic                   HRESP;
    logic [N_SLAVES-1:0]    S_HSEL;
    logic [N_SLAVES-1:0]    S_HREADYOUT;
    logic [32*N_SLAVES-1:0] S_HRDATA;
    logic [N_SLAVES-1:0]    S_HRESP;

    modport master (
        output HADDR, HTRANS, S_HREADYOUT, S_HRDATA, S_HRESP,
        input  HREADY, HRDATA, HRESP, S_HSEL
    );

    modport slave (
        input  HADDR, HTRANS, S_HREADYOUT, S_HRDATA, S_HRESP,
        output HREADY, HRDATA, HRESP, S_HSEL
    );
endinterface

// File: rtl/mfp_ahb_lite_param_interconnect.sv
// Single-master AHB-Lite interconnect: mask/match decoder, data-phase response mux
// and a built-in default slave that answers unmapped transfers with a 2-cycle ERROR.
module mfp_ahb_lite_param_interconnect #(
    parameter int                      N_SLAVES   = 4,
    parameter logic [32*N_SLAVES-1:0]  ADDR_MATCH = {N_SLAVES{32'h0}},
    parameter logic [32*N_SLAVES-1:0]  ADDR_MASK  = {N_SLAVES{32'h0}},
    parameter int                      CNT_WIDTH  = 16
) (
    input  logic                                 HCLK,
    input  logic                                 HRESET,
    mfp_ahb_lite_param_interconnect_if.slave     bus,
    output logic [CNT_WIDTH-1:0]                 ERR_COUNT,
    output logic [31:0]                          ERR_ADDR
);

    // HADDR[31:29] selects kseg0/kseg1/etc. and must alias onto the same slave.
    localparam logic [31:0] DECODE_BITS = 32'h1FFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    logic [N_SLAVES-1:0]  hit;
    logic [N_SLAVES-1:0]  hsel;
    logic                 no_hit;
    logic                 err_start;

    logic [N_SLAVES-1:0]  dsel_reg, dsel_next;
    logic                 dflt_reg, dflt_next;
    state_t               state_reg, state_next;
    logic [CNT_WIDTH-1:0] err_count_reg, err_count_next;
    logic [31:0]          err_addr_reg, err_addr_next;

    logic [31:0]          slot_rdata [N_SLAVES];
    logic [31:0]          slave_rdata;
    logic                 slave_ready;
    logic                 slave_resp;
    logic                 hready;
    logic                 unused_htrans0;

    assign unused_htrans0 = bus.HTRANS[0];

    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_decode
            localparam logic [31:0] SLOT_MASK  = ADDR_MASK[32*gi +: 32] & DECODE_BITS;
            localparam logic [31:0] SLOT_MATCH = ADDR_MATCH[32*gi +: 32] & SLOT_MASK;
            assign hit[gi] = ((bus.HADDR & SLOT_MASK) == SLOT_MATCH);
        end
    endgenerate

    // Isolate the lowest set bit so overlapping windows resolve to the lowest index.
    assign hsel   = hit & (~hit + {{(N_SLAVES-1){1'b0}}, 1'b1});
    assign no_hit = ~|hit;

    assign bus.S_HSEL = hsel;

    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_rdata
            assign slot_rdata[gi] = bus.S_HRDATA[32*gi +: 32] & {32{dsel_reg[gi]}};
        end
    endgenerate

    always_comb begin
        slave_rdata = 32'h0;
        for (int i = 0; i < N_SLAVES; i++) begin
            slave_rdata = slave_rdata | slot_rdata[i];
        end
    end

    assign slave_ready = |(dsel_reg & bus.S_HREADYOUT);
    assign slave_resp  = |(dsel_reg & bus.S_HRESP);

    // Only the data-phase owner drives HREADY; the default slave owns it whenever dflt is set.
    assign hready     = dflt_reg ? (state_reg != ST_ERR1) : slave_ready;
    assign bus.HREADY = hready;
    assign bus.HRESP  = dflt_reg ? (state_reg != ST_IDLE) : slave_resp;
    assign bus.HRDATA = dflt_reg ? 32'h0 : slave_rdata;

    assign err_start = hready & no_hit & bus.HTRANS[1];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dsel_reg      <= '0;
            dflt_reg      <= 1'b1;
            state_reg     <= ST_IDLE;
            err_count_reg <= '0;
            err_addr_reg  <= 32'h0;
        end else begin
            dsel_reg      <= dsel_next;
            dflt_reg      <= dflt_next;
            state_reg     <= state_next;
            err_count_reg <= err_count_next;
            err_addr_reg  <= err_addr_next;
        end
    end

    always_comb begin
        dsel_next      = dsel_reg;
        dflt_next      = dflt_reg;
        state_next     = state_reg;
        err_count_next = err_count_reg;
        err_addr_next  = err_addr_reg;

        if (hready) begin
            dsel_next = hsel;
            dflt_next = no_hit;
        end

        case (state_reg)
            ST_IDLE: if (err_start) state_next = ST_ERR1;
            ST_ERR1: state_next = ST_ERR2;
            ST_ERR2: state_next = err_start ? ST_ERR1 : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // err_start can only be true in IDLE or ERR2, since ERR1 holds HREADY low.
        if (err_start) begin
            err_addr_next = bus.HADDR;
            if (err_count_reg != {CNT_WIDTH{1'b1}}) begin
                err_count_next = err_count_reg + 1'b1;
            end
        end
    end

    assign ERR_COUNT = err_count_reg;
    assign ERR_ADDR  = err_addr_reg;

endmodule

// File: tb/tb_mfp_ahb_lite_param_interconnect.sv
// Directed and randomized bench for the AHB-Lite interconnect, checked against a
// transaction-level model of decode, data-phase ownership and the error response.
module tb_mfp_ahb_lite_param_interconnect;

    localparam logic [127:0] MATCH_A = {32'h0C00_0000, 32'h0800_0000, 32'h0000_0000, 32'h0800_0000};
    localparam logic [127:0] MASK_A  = {32'h1F00_0000, 32'h1C00_0000, 32'h1C00_0000, 32'h1FF0_0000};

    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    mfp_ahb_lite_param_interconnect_if #(.N_SLAVES(4)) bus_a ();
    mfp_ahb_lite_param_interconnect_if #(.N_SLAVES(1)) bus_b ();

    logic [15:0] err_count_a;
    logic [31:0] err_addr_a;
    logic [1:0]  err_count_b;
    logic [31:0] err_addr_b;

    mfp_ahb_lite_param_interconnect #(
        .N_SLAVES   (4),
        .ADDR_MATCH (MATCH_A),
        .ADDR_MASK  (MASK_A),
        .CNT_WIDTH  (16)
    ) dut_a (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .bus       (bus_a),
        .ERR_COUNT (err_count_a),
        .ERR_ADDR  (err_addr_a)
    );

    mfp_ahb_lite_param_interconnect #(
        .N_SLAVES   (1),
        .ADDR_MATCH (32'h0000_0000),
        .ADDR_MASK  (32'h1F00_0000),
        .CNT_WIDTH  (2)
    ) dut_b (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .bus       (bus_b),
        .ERR_COUNT (err_count_b),
        .ERR_ADDR  (err_addr_b)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: who owns the data phase (-1 = default slave) and error progress.
    int          m_own;
    int          m_phase;
    int unsigned m_cnt;
    logic [31:0] m_eaddr;

    logic        obs_hready, obs_hresp;
    logic [31:0] obs_hrdata;
    logic [3:0]  obs_hsel;
    logic [15:0] obs_cnt;
    logic [31:0] obs_eaddr;

    function automatic int decode_a(input logic [31:0] a);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m = MASK_A[32*i +: 32] & 32'h1FFF_FFFF;
            if ((a & m) == (MATCH_A[32*i +: 32] & m)) return i;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own   = -1;
        m_phase = 0;
        m_cnt   = 0;
        m_eaddr = 32'h0;
    endtask

    // One bus cycle on instance A: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step_a();
        int          hit;
        logic        e_ready, e_resp;
        logic [31:0] e_rdata;
        logic [3:0]  e_hsel;
        logic [31:0] haddr_s;
        logic        tr1_s;
        @(negedge HCLK);
        haddr_s = bus_a.HADDR;
        tr1_s   = bus_a.HTRANS[1];
        hit     = decode_a(haddr_s);
        e_hsel  = (hit < 0) ? 4'b0000 : 4'(1 << hit);
        if (m_own >= 0) begin
            e_ready = bus_a.S_HREADYOUT[m_own];
            e_resp  = bus_a.S_HRESP[m_own];
            e_rdata = bus_a.S_HRDATA[32*m_own +: 32];
        end else begin
            e_ready = (m_phase != 1);
            e_resp  = (m_phase != 0);
            e_rdata = 32'h0;
        end
        obs_hready = bus_a.HREADY;
        obs_hresp  = bus_a.HRESP;
        obs_hrdata = bus_a.HRDATA;
        obs_hsel   = bus_a.S_HSEL;
        obs_cnt    = err_count_a;
        obs_eaddr  = err_addr_a;
        check("hready", 32'(obs_hready), 32'(e_ready));
        check("hresp", 32'(obs_hresp), 32'(e_resp));
        check("hrdata", obs_hrdata, e_rdata);
        check("s_hsel", 32'(obs_hsel), 32'(e_hsel));
        check("err_count", 32'(obs_cnt), m_cnt);
        check("err_addr", obs_eaddr, m_eaddr);
        @(posedge HCLK);
        if (e_ready) begin
            if (hit < 0 && tr1_s) begin
                m_phase = 1;
                if (m_cnt != 32'd65535) m_cnt++;
                m_eaddr = haddr_s;
            end else begin
                m_phase = 0;
            end
            m_own = hit;
        end else if (m_own < 0) begin
            m_phase = 2;
        end
        #1;
    endtask

    initial begin
        int low;
        HRESET = 1'b1;
        bus_a.HADDR = 32'h0; bus_a.HTRANS = 2'b00;
        bus_a.S_HREADYOUT = 4'hF; bus_a.S_HRDATA = '0; bus_a.S_HRESP = 4'h0;
        bus_b.HADDR = 32'h0; bus_b.HTRANS = 2'b00;
        bus_b.S_HREADYOUT = 1'b1; bus_b.S_HRDATA = 32'h5A5A_0001; bus_b.S_HRESP = 1'b0;
        model_reset();
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Reset state on an idle bus.
        step_a();
        step_a();

        // Slot 1 read through a kseg alias with three wait states.
        bus_a.HADDR = 32'h8000_0010; bus_a.HTRANS = 2'b10;
        step_a();
        check("t2_hsel", 32'(obs_hsel), 32'h2);
        bus_a.HTRANS = 2'b00; bus_a.HADDR = 32'h0;
        bus_a.S_HREADYOUT = 4'b1101; bus_a.S_HRDATA[63:32] = 32'hCAFE_0001;
        low = 0;
        repeat (3) begin
            step_a();
            if (!obs_hready) low++;
        end
        bus_a.S_HREADYOUT = 4'hF;
        step_a();
        check("t2_wait_cycles", 32'(low), 32'd3);
        check("t2_ready", 32'(obs_hready), 32'd1);
        check("t2_rdata", obs_hrdata, 32'hCAFE_0001);

        // Unmapped NONSEQ, cancelled during ERR1, then a back-to-back error from ERR2.
        bus_a.HADDR = 32'hB000_0000; bus_a.HTRANS = 2'b10;
        step_a();
        bus_a.HADDR = 32'h0000_0100; bus_a.HTRANS = 2'b00;
        step_a();
        check("t3_err1_ready", 32'(obs_hready), 32'd0);
        check("t3_err1_resp", 32'(obs_hresp), 32'd1);
        bus_a.HADDR = 32'hD000_0000; bus_a.HTRANS = 2'b10;
        step_a();
        check("t3_err2_ready", 32'(obs_hready), 32'd1);
        check("t3_err2_resp", 32'(obs_hresp), 32'd1);
        check("t3_count", 32'(obs_cnt), 32'd1);
        check("t3_addr", obs_eaddr, 32'hB000_0000);
        bus_a.HTRANS = 2'b00;
        step_a();
        check("t4_err1_ready", 32'(obs_hready), 32'd0);
        check("t4_count", 32'(obs_cnt), 32'd2);
        bus_a.HADDR = 32'hF000_0000;
        step_a();
        step_a();
        check("t4_idle_ready", 32'(obs_hready), 32'd1);
        check("t4_idle_resp", 32'(obs_hresp), 32'd0);
        check("t4_idle_count", 32'(obs_cnt), 32'd2);
        check("t4_addr", obs_eaddr, 32'hD000_0000);

        // Overlapping slots 0 and 2: slot 0 wins.
        bus_a.S_HRDATA = {32'h0000_DDDD, 32'h0000_BBBB, 32'h0000_9999, 32'h0000_AAAA};
        bus_a.HADDR = 32'h0800_0040; bus_a.HTRANS = 2'b10;
        step_a();
        check("t5_hsel", 32'(obs_hsel), 32'h1);
        bus_a.HTRANS = 2'b00;
        step_a();
        check("t5_rdata", obs_hrdata, 32'h0000_AAAA);

        // Narrow counter on the single-slot instance saturates at 3.
        bus_b.HADDR = 32'h0100_0000; bus_b.HTRANS = 2'b10;
        step_a();
        check("t6_first_count", 32'(err_count_b), 32'd1);
        check("t6_first_ready", 32'(bus_b.HREADY), 32'd0);
        repeat (10) step_a();
        bus_b.HTRANS = 2'b00;
        repeat (3) step_a();
        check("t6_sat_count", 32'(err_count_b), 32'd3);
        check("t6_addr", err_addr_b, 32'h0100_0000);
        bus_b.HADDR = 32'h8000_0004; bus_b.HTRANS = 2'b10;
        @(negedge HCLK);
        check("n1_hsel", 32'(bus_b.S_HSEL), 32'd1);
        step_a();
        bus_b.HTRANS = 2'b00;
        @(negedge HCLK);
        check("n1_rdata", bus_b.HRDATA, 32'h5A5A_0001);
        check("n1_resp", 32'(bus_b.HRESP), 32'd0);
        step_a();

        // Randomized traffic with random slave waits, data and responses.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0: bus_a.HADDR = $urandom & 32'hE3FF_FFFF;
                1: bus_a.HADDR = ($urandom & 32'hE00F_FFFF) | 32'h0800_0000;
                2: bus_a.HADDR = ($urandom & 32'hE3FF_FFFF) | 32'h0800_0000;
                3: bus_a.HADDR = ($urandom & 32'hE0FF_FFFF) | 32'h0C00_0000;
                4: bus_a.HADDR = $urandom | 32'h1000_0000;
                default: bus_a.HADDR = $urandom;
            endcase
            bus_a.HTRANS      = 2'($urandom_range(0, 3));
            bus_a.S_HREADYOUT = 4'($urandom | $urandom);
            bus_a.S_HRDATA    = {$urandom, $urandom, $urandom, $urandom};
            bus_a.S_HRESP     = 4'($urandom & $urandom & $urandom);
            step_a();
        end

        // Asynchronous reset while the default slave sits in ERR1.
        bus_a.S_HREADYOUT = 4'hF; bus_a.S_HRESP = 4'h0;
        bus_a.HTRANS = 2'b00;
        repeat (4) step_a();
        bus_a.HADDR = 32'h1234_5678; bus_a.HTRANS = 2'b11;
        step_a();
        bus_a.HTRANS = 2'b00;
        check("t1_pre_ready", 32'(bus_a.HREADY), 32'd0);
        HRESET = 1'b1;
        #1;
        check("t1_ready", 32'(bus_a.HREADY), 32'd1);
        check("t1_resp", 32'(bus_a.HRESP), 32'd0);
        check("t1_rdata", bus_a.HRDATA, 32'h0);
        check("t1_count", 32'(err_count_a), 32'd0);
        model_reset();
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        step_a();
        step_a();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
